seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed multi-digit BCD to 7-segment display driver. It holds NUM_DIGITS BCD digits and scans them onto one shared segment bus with per-digit anode enables. It adds double-buffered, tear-free updates, leading-zero blanking, decimal points and selectable output polarity. It sits between the counter/datapath logic that produces BCD values and the board's multiplexed display pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles each digit is displayed; minimum 2.
- ACTIVE_LOW_SEG, 1: 1 means segments and dp are driven low to light; 0 means driven high.
- ACTIVE_LOW_AN, 1: 1 means an anode is driven low to enable its digit; 0 means driven high.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe that captures bcd_in and dp_in into the shadow register.
- bcd_in  in  4*NUM_DIGITS  digit i occupies bits [4i+3:4i]; digit 0 is least significant and rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit; 1 means lit.
- blank_lz  in  1  leading-zero blanking enable; sampled every cycle.
- seg_out  out  7  segment bus; bit0=a, bit1=b, …, bit6=g.
- dp_out  out  1  decimal point for the currently enabled digit.
- an_out  out  NUM_DIGITS  digit enables; exactly one is active outside reset.
- frame_done  out  1  one-cycle pulse when a new frame starts.

## Operation
- **Prescaler.** cnt counts 0..REFRESH_DIV-1. A tick occurs on the cycle where cnt==REFRESH_DIV-1; on that edge cnt returns to 0.
- **Digit index.** idx advances on each tick and wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS=1, idx stays 0 and every tick is a wrap.
- **Shadow register.** Written on any cycle where load=1; a later load overwrites an earlier one.
- **Active register.** Holds the data being displayed. It is written only on a wrap edge (the tick where idx goes to 0), so a frame never mixes old and new data.
  - If load=1 on the wrap cycle, the active register takes bcd_in/dp_in directly (same-cycle pass-through).
- **frame_done.** Set to 1 on the wrap edge, 0 otherwise.
- **Decode.** Active-low raw patterns, inverted when ACTIVE_LOW_SEG=0:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10..15 = all segments off
- **Leading-zero blanking.** When blank_lz=1, digit i (i≥1) is blanked if it and every higher digit equal 0. Digit 0 is never blanked. Invalid codes count as non-zero.
  - Blanked digit: segments off, anode still enabled, dp_out still follows its dp bit.
- **Outputs.** an_out enables bit idx only. seg_out and dp_out carry the selected digit. All three are registered.

## Timing
- **Reset values.** All registers are cleared; shadow and active registers become 0.
  - an_out: all inactive (all 1 when ACTIVE_LOW_AN=1).
  - seg_out: all off. dp_out: off.
  - frame_done: 0.
- **After reset release.** cnt starts at 0 and idx at 0. On the first edge, outputs show digit 0 with active value 0, i.e. a "0" pattern. Active data stays 0 until the first wrap after a load.
- **Output latency.** Outputs lag idx/active register changes by exactly 1 cycle. Each digit is shown for exactly REFRESH_DIV cycles; a frame is NUM_DIGITS*REFRESH_DIV cycles.
- **frame_done alignment.** frame_done rises on the same edge idx becomes 0. The outputs show the new frame's digit 0 one cycle later.
- **Load to display.** Load-to-visible latency runs from the next wrap edge plus 1 cycle, up to one frame plus 1 cycle.
- **Reset mid-frame.** Same as power-on reset: pending shadow data is discarded.
- **blank_lz changes.** Take effect on the next output register update, not at the frame boundary.

## Test plan
Parameters for all scenarios unless stated: NUM_DIGITS=4, REFRESH_DIV=4, both polarities active-low.
1. **Reset.** Hold rst for 3 cycles. Required: an_out=1111, seg_out=1111111, dp_out=1, frame_done=0. The first cycle after release shows an_out=1110, seg_out=1000000.
2. **Scan.** load bcd_in=16'h1234, dp_in=4'b0010. After the next frame_done, each pattern holds for 4 cycles:
   - an_out=1110 with seg 0011001
   - an_out=1101 with seg 0110000 and dp_out=0
   - an_out=1011 with seg 0100100
   - an_out=0111 with seg 1111001
3. **Blanking.** bcd_in=16'h0050 with blank_lz=1: digits 3 and 2 show 1111111 (anodes still cycle), digit 1 shows 0010010, digit 0 shows 1000000. With blank_lz=0, digits 3 and 2 show 1000000. With bcd_in=16'h0A00, digit 3 is blanked and digit 2 shows 1111111 as an invalid code.
4. **Tear-free update.** Load 16'h1111 while idx=1, then 16'h2222 while idx=2. Required: the current frame completes with the old data; the next frame shows all four digits as 2 (0100100); 16'h1111 is never displayed. frame_done pulses exactly every 16 cycles. A load on the wrap cycle appears in the very next frame.
5. **Polarity and size.** ACTIVE_LOW_SEG=0, ACTIVE_LOW_AN=0, NUM_DIGITS=1, load digit 8. Required: an_out=1 constantly and seg_out=1111111. frame_done pulses every 4 cycles.
6. **Mid-frame reset.** Assert rst for 1 cycle at idx=2 with a pending load. Required: reset values next cycle, then the scan restarts at digit 0 showing "0".

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed BCD to 7-segment scan driver with tear-free double buffering
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = (ACTIVE_LOW_SEG != 0) ? 7'h7f : 7'h00;
    localparam logic                  DP_OFF   = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] active_bcd_q, active_bcd_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    wrap;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [3:0]              sel_code;
    logic                    sel_dp;
    logic                    sel_blank;
    logic [6:0]              seg_raw;

    // Raw patterns are active-low (bit0=a .. bit6=g); invalid codes light nothing.
    function automatic logic [6:0] decode_raw(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    always_comb begin
        tick = (cnt_q == CNT_LAST);
        wrap = tick && (idx_q == IDX_LAST);

        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = '0;
        end else if (tick) begin
            idx_d = idx_q + IDX_W'(1);
        end

        frame_done_d = wrap;

        shadow_bcd_d = load ? bcd_in : shadow_bcd_q;
        shadow_dp_d  = load ? dp_in  : shadow_dp_q;

        // Active data only changes at the frame boundary; a load on that same edge passes straight through.
        active_bcd_d = active_bcd_q;
        active_dp_d  = active_dp_q;
        if (wrap) begin
            active_bcd_d = load ? bcd_in : shadow_bcd_q;
            active_dp_d  = load ? dp_in  : shadow_dp_q;
        end
    end

    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (active_bcd_q[4*i +: 4] == 4'd0);
            if (i != 0) begin
                blank_mask[i] = blank_lz && zero_run;
            end
        end
    end

    always_comb begin
        sel_code  = 4'd0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_code     = active_bcd_q[4*i +: 4];
                sel_dp       = active_dp_q[i];
                sel_blank    = blank_mask[i];
                an_onehot[i] = 1'b1;
            end
        end

        seg_raw = sel_blank ? 7'b1111111 : decode_raw(sel_code);
        seg_d   = (ACTIVE_LOW_SEG != 0) ? seg_raw : ~seg_raw;
        dp_d    = (ACTIVE_LOW_SEG != 0) ? ~sel_dp : sel_dp;
        an_d    = (ACTIVE_LOW_AN != 0) ? ~an_onehot : an_onehot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            active_bcd_q <= '0;
            active_dp_q  <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            active_bcd_q <= active_bcd_d;
            active_dp_q  <= active_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SOFF = 7'b1111111;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        blz;
        logic [27:0] seg;
        logic [3:0]  dpo;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, blank_lz;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    logic        rst1, load1, blz1;
    logic [3:0]  bcd1;
    logic [0:0]  dp1;
    logic [6:0]  seg1;
    logic        dpo1;
    logic [0:0]  an1;
    logic        fd1;

    int errors = 0;
    int checks = 0;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out),
        .an_out(an_out), .frame_done(frame_done)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(1), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0)
    ) dut1 (
        .clk(clk), .rst(rst1), .load(load1), .bcd_in(bcd1), .dp_in(dp1),
        .blank_lz(blz1), .seg_out(seg1), .dp_out(dpo1),
        .an_out(an1), .frame_done(fd1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        chk("fd_seen", 32'(frame_done), 32'd1);
    endtask

    function automatic vec_t mk(input logic [15:0] bcd, input logic [3:0] dp, input logic blz,
                                input logic [27:0] seg, input logic [3:0] dpo);
        vec_t v;
        v.bcd = bcd; v.dp = dp; v.blz = blz; v.seg = seg; v.dpo = dpo;
        return v;
    endfunction

    // 32-cycle window starting at a frame_done edge: optional loads at steps k1/k2,
    // first frame expects pattern sa on every digit, second frame expects sb.
    task automatic run_window(input logic [15:0] b1, input int k1, input logic [15:0] b2, input int k2,
                              input logic [6:0] sa, input logic [6:0] sb, input string tag);
        int d;
        logic [3:0] ean;
        for (int k = 1; k <= 32; k++) begin
            load   = (k == k1) || (k == k2);
            bcd_in = (k == k2) ? b2 : b1;
            step();
            load = 1'b0;
            d   = ((k - 1) / 4) % 4;
            ean = ~(4'b0001 << d);
            chk($sformatf("%s_k%0d_an", tag, k), 32'(an_out), 32'(ean));
            chk($sformatf("%s_k%0d_seg", tag, k), 32'(seg_out), 32'((k <= 16) ? sa : sb));
            chk($sformatf("%s_k%0d_fd", tag, k), 32'(frame_done), 32'((k == 16) || (k == 32)));
        end
    endtask

    vec_t        tbl[6];
    int          n;
    logic [27:0] s;
    logic [3:0]  ean;

    initial begin
        tbl[0] = mk(16'h1234, 4'b0010, 1'b0, {S1, S2, S3, S4}, 4'b1101);
        tbl[1] = mk(16'h0050, 4'b0000, 1'b1, {SOFF, SOFF, S5, S0}, 4'b1111);
        tbl[2] = mk(16'h0050, 4'b0000, 1'b0, {S0, S0, S5, S0}, 4'b1111);
        tbl[3] = mk(16'h0A00, 4'b0000, 1'b1, {SOFF, SOFF, S0, S0}, 4'b1111);
        tbl[4] = mk(16'h0000, 4'b1111, 1'b1, {SOFF, SOFF, SOFF, S0}, 4'b0000);
        tbl[5] = mk(16'h9876, 4'b1000, 1'b1, {S9, S8, S7, S6}, 4'b0111);

        rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
        rst1 = 1'b1; load1 = 1'b0; bcd1 = '0; dp1 = '0; blz1 = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", 32'(an_out), 32'hf);
            chk("rst_seg", 32'(seg_out), 32'(SOFF));
            chk("rst_dp", 32'(dp_out), 32'd1);
            chk("rst_fd", 32'(frame_done), 32'd0);
        end
        chk("rst1_an", 32'(an1), 32'd0);
        chk("rst1_seg", 32'(seg1), 32'd0);
        chk("rst1_dp", 32'(dpo1), 32'd0);
        chk("rst1_fd", 32'(fd1), 32'd0);

        rst = 1'b0; rst1 = 1'b0;
        step();
        chk("rel_an", 32'(an_out), 32'he);
        chk("rel_seg", 32'(seg_out), 32'(S0));
        chk("rel_dp", 32'(dp_out), 32'd1);
        chk("rel_fd", 32'(frame_done), 32'd0);
        wait_fd(n);
        chk("first_fd_delay", 32'(n), 32'd15);
        wait_fd(n);
        chk("fd_period", 32'(n), 32'd16);

        for (int v = 0; v < 6; v++) begin
            bcd_in = tbl[v].bcd; dp_in = tbl[v].dp; blank_lz = tbl[v].blz;
            load = 1'b1;
            step();
            load = 1'b0;
            wait_fd(n);
            s = tbl[v].seg;
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    ean = ~(4'b0001 << d);
                    chk($sformatf("v%0d_d%0d_an", v, d), 32'(an_out), 32'(ean));
                    chk($sformatf("v%0d_d%0d_seg", v, d), 32'(seg_out), 32'(s[7*d +: 7]));
                    chk($sformatf("v%0d_d%0d_dp", v, d), 32'(dp_out), 32'(tbl[v].dpo[d]));
                    chk($sformatf("v%0d_d%0d_fd", v, d), 32'(frame_done), 32'((d == 3) && (c == 3)));
                end
            end
        end

        blank_lz = 1'b0; dp_in = '0; bcd_in = 16'h3333;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_fd(n);
        run_window(16'h1111, 5, 16'h2222, 9, S3, S2, "tear");
        run_window(16'h4444, 16, 16'h4444, -1, S2, S4, "wrapload");

        for (int i = 0; i < 8; i++) step();
        bcd_in = 16'h7777; load = 1'b1;
        step();
        load = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_an", 32'(an_out), 32'hf);
        chk("mid_rst_seg", 32'(seg_out), 32'(SOFF));
        chk("mid_rst_dp", 32'(dp_out), 32'd1);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        step();
        chk("mid_rel_an", 32'(an_out), 32'he);
        chk("mid_rel_seg", 32'(seg_out), 32'(S0));
        wait_fd(n);
        chk("mid_first_fd_delay", 32'(n), 32'd15);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("mid_discard_k%0d_seg", k), 32'(seg_out), 32'(S0));
        end

        bcd1 = 4'd8; load1 = 1'b1;
        step();
        load1 = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (fd1 !== 1'b1 && n < 16);
        chk("one_fd_seen", 32'(fd1), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("one_k%0d_an", k), 32'(an1), 32'd1);
            chk($sformatf("one_k%0d_seg", k), 32'(seg1), 32'h7f);
            chk($sformatf("one_k%0d_dp", k), 32'(dpo1), 32'd0);
            chk($sformatf("one_k%0d_fd", k), 32'(fd1), 32'((k % 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
